// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for a 5-stage in-order core: tracks X/M stage
// records, picks the PC source, forwarding selects, stalls and flushes.
module pipeline_controller (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] inst,
  input  logic        branch_taken,
  input  logic        uart_sel,
  input  logic        mem_ready,
  output logic [1:0]  PC_sel,
  output logic [1:0]  data_forward_ALU1,
  output logic [1:0]  data_forward_ALU2,
  output logic        RegWr,
  output logic [1:0]  MemToReg,
  output logic        stall,
  output logic        flush,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CntW = 16;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
    logic       is_jump;
  } rec_t;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_LDSTALL, S_MEMWAIT} state_t;

  // Stage record for the instruction in Decode; x0 destinations never write.
  function automatic rec_t decode(input logic [11:0] lo);
    rec_t r;
    logic writer;
    r = '0;
    unique case (lo[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0010011, 7'b0110011: writer = 1'b1;
      default:                            writer = 1'b0;
    endcase
    r.rd      = lo[11:7];
    r.wr      = writer && (lo[11:7] != 5'd0);
    r.is_load = (lo[6:0] == 7'b0000011);
    r.is_jump = (lo[6:0] == 7'b1101111) || (lo[6:0] == 7'b1100111);
    return r;
  endfunction

  state_t          state_q, state_d;
  rec_t            x_q, x_d, m_q, m_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [4:0] rs1, rs2;
  logic       hold, redirect, load_use;
  logic [1:0] fwd1_c, fwd2_c, mtr_c;
  logic       unused_inst;

  assign rs1         = inst[19:15];
  assign rs2         = inst[24:20];
  assign unused_inst = ^{inst[31:25], inst[14:12]};

  // Hazard conditions derived from the registered stage records.
  assign hold     = m_q.is_load && !mem_ready;
  assign redirect = branch_taken || x_q.is_jump;
  assign load_use = x_q.is_load && x_q.wr && ((x_q.rd == rs1) || (x_q.rd == rs2));

  // Forward selects: X (non-load) beats M; x0 is excluded via wr.
  assign fwd1_c = (x_q.wr && !x_q.is_load && (x_q.rd == rs1)) ? 2'd1 :
                  (m_q.wr && (m_q.rd == rs1))                  ? 2'd2 : 2'd0;
  assign fwd2_c = (x_q.wr && !x_q.is_load && (x_q.rd == rs2)) ? 2'd1 :
                  (m_q.wr && (m_q.rd == rs2))                  ? 2'd2 : 2'd0;

  // Writeback source for the instruction in M.
  assign mtr_c = m_q.is_jump ? 2'd0 :
                 m_q.is_load ? (uart_sel ? 2'd3 : 2'd2) : 2'd1;

  // State, stage records and stall counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_BOOT;
      x_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and outputs; priority is memory wait > redirect > load-use > advance.
  always_comb begin
    state_d           = state_q;
    x_d               = x_q;
    m_d               = m_q;
    cnt_d             = cnt_q;
    PC_sel            = 2'd1;
    stall             = 1'b0;
    flush             = 1'b0;
    RegWr             = m_q.wr;
    MemToReg          = mtr_c;
    data_forward_ALU1 = fwd1_c;
    data_forward_ALU2 = fwd2_c;

    if (Reset || (state_q == S_BOOT)) begin
      PC_sel            = 2'd2;
      flush             = 1'b1;
      RegWr             = 1'b0;
      MemToReg          = 2'd0;
      data_forward_ALU1 = 2'd0;
      data_forward_ALU2 = 2'd0;
      x_d               = '0;
      m_d               = '0;
      state_d           = S_RUN;
    end else if (hold) begin
      PC_sel  = 2'd0;
      stall   = 1'b1;
      RegWr   = 1'b0;
      state_d = S_MEMWAIT;
    end else if (redirect) begin
      PC_sel  = 2'd3;
      flush   = 1'b1;
      m_d     = x_q;
      x_d     = '0;
      state_d = S_RUN;
    end else if (load_use) begin
      PC_sel  = 2'd0;
      stall   = 1'b1;
      m_d     = x_q;
      x_d     = '0;
      state_d = S_LDSTALL;
    end else begin
      m_d     = x_q;
      x_d     = decode(inst[11:0]);
      state_d = S_RUN;
    end

    if (stall && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have ports: Clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: Reset  input  1  synchronous, active-high; sampled on Clock rising edge only.
REQ-003 SHALL have: inst  input  32  instruction currently in Decode (D) stage.
REQ-004 SHALL have: branch_taken  input  1  branch in Execute (X) resolved taken.
REQ-005 SHALL have: uart_sel  input  1  load in Memory (M) stage targets UART.
REQ-006 SHALL have: mem_ready  input  1  dmem/UART read data valid this cycle.
REQ-007 SHALL have: PC_sel  output  2  0 hold, 1 PC+4, 2 PC<=0, 3 branch/jump target.
REQ-008 SHALL have: data_forward_ALU1, data_forward_ALU2  output  2 each  0 regfile, 1 from X, 2 from M.
REQ-009 SHALL have: RegWr  output  1; MemToReg  output  2  0 PC+4, 1 ALU, 2 dmem, 3 UART.
REQ-010 SHALL have: stall  output  1; flush  output  1; stall_cycles  output  16  saturating stall counter.

Function
REQ-011 SHALL track X and M stage records {rd[4:0], wr, is_load, is_jump}, decoded from inst[11:7], inst[6:0].
REQ-012 Writers SHALL be LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011; BRANCH, STORE and unknown opcodes SHALL have wr=0.
REQ-013 Record with rd=0 SHALL have wr=0 (x0 never written or forwarded).
REQ-014 FSM states: BOOT, RUN, LDSTALL, MEMWAIT.
REQ-015 BOOT: PC_sel=2, flush=1, X/M records cleared; next state RUN unconditionally.
REQ-016 MEMWAIT entered from RUN when M.is_load=1 and mem_ready=0; PC_sel=0, stall=1, all records frozen, RegWr=0; exit to RUN in the cycle mem_ready=1 (RegWr asserted that cycle).
REQ-017 Redirect (RUN, not entering MEMWAIT): branch_taken=1 or X.is_jump=1 -> PC_sel=3, flush=1, D instruction replaced by bubble entering X.
REQ-018 Load-use (RUN, no redirect): X.is_load=1, X.wr=1, X.rd equals D rs1 (inst[19:15]) or rs2 (inst[24:20]) -> enter LDSTALL: PC_sel=0, stall=1, bubble into X, D held.
REQ-019 LDSTALL SHALL last exactly one cycle, then RUN; data then forwarded from M (code 2).
REQ-020 Priority SHALL be MEMWAIT > redirect > load-use > normal (PC_sel=1).
REQ-021 data_forward_ALU1: 1 if X.wr and !X.is_load and X.rd==rs1; else 2 if M.wr and M.rd==rs1; else 0; ALU2 identically with rs2; X match wins over M.
REQ-022 RegWr SHALL equal M.wr except 0 in MEMWAIT-hold, BOOT and Reset.
REQ-023 MemToReg from M record: is_jump->0, is_load&uart_sel->3, is_load->2, else 1.
REQ-024 Normal advance: M<=X, X<=decode(inst) each RUN cycle without stall/flush.
REQ-025 stall_cycles SHALL increment on every cycle with stall=1, saturating at 16'hFFFF.
REQ-026 Outputs SHALL be functions of registered state and current inputs; no combinational path from mem_ready to records.

Reset
REQ-027 Reset=1 SHALL force: state BOOT, X/M records cleared, stall_cycles=0, PC_sel=2, RegWr=0, MemToReg=0, forwards=0, stall=0, flush=1.
REQ-028 Reset asserted mid-MEMWAIT or LDSTALL SHALL abandon it; first cycle after release is BOOT.

Verification
REQ-029 Release Reset -> one cycle PC_sel=2, flush=1, then PC_sel=1 with RegWr=0 for two cycles.
REQ-030 ADD x5 then ADD x6,x5,x5 -> data_forward_ALU1=1, ALU2=1, no stall.
REQ-031 LW x5 then ADD x6,x5,x0 -> one cycle stall=1, PC_sel=0; next cycle data_forward_ALU1=2; stall_cycles=1.
REQ-032 Taken branch in X with mem_ready=1 -> PC_sel=3, flush=1, bubble (RegWr=0) reaches M next cycle.
REQ-033 LW to UART, mem_ready low 3 cycles -> PC_sel=0 for 3 cycles, RegWr=0, then RegWr=1, MemToReg=3.
REQ-034 ADD x0,x1,x2 followed by ADD x3,x0,x0 -> forwards stay 0, RegWr=0 at M.
